// File: rtl/fsb8_target.sv
// FSB8 bus target: decodes a 32-bit address from two ALE phases and hands hits
// to a local request/acknowledge port, returning read data and RDY# to the master.
module fsb8_target #(
  parameter logic [31:0] BASE_ADDR = 32'hC000_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ale_n,
  input  logic        cs_n,
  input  logic        cmd_n,
  input  logic        typ,
  input  logic        wr_n,
  input  logic [7:0]  aah8,
  input  logic [7:0]  ad_in,
  output logic [7:0]  ad_out,
  output logic        ad_oe,
  output logic        rdy_n,
  output logic        irq_n,
  output logic [31:0] loc_addr,
  output logic [7:0]  loc_wdata,
  output logic        loc_we,
  output logic        loc_req,
  input  logic        loc_ack,
  input  logic [7:0]  loc_rdata,
  input  logic        loc_irq
);

  typedef enum logic [2:0] {StIdle, StAdr1, StDec, StReq, StRdy, StTurn} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        loc_req_q, loc_req_d;
  logic        loc_we_q, loc_we_d;
  logic [7:0]  loc_wdata_q, loc_wdata_d;
  logic [7:0]  ad_out_q, ad_out_d;
  logic        ad_oe_q, ad_oe_d;
  logic        abort_q, abort_d;
  logic        irq_n_q;
  logic        hit;

  assign hit = ((addr_q & ADDR_MASK) == (BASE_ADDR & ADDR_MASK)) && cmd_n;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    loc_req_d   = loc_req_q;
    loc_we_d    = loc_we_q;
    loc_wdata_d = loc_wdata_q;
    ad_out_d    = ad_out_q;
    ad_oe_d     = ad_oe_q;
    abort_d     = abort_q;
    unique case (state_q)
      StIdle: begin
        if (!ale_n) begin
          addr_d[15:0] = {aah8, ad_in};
          state_d      = StAdr1;
        end
      end
      StAdr1: begin
        if (!ale_n) begin
          addr_d[31:16] = {aah8, ad_in};
          state_d       = StDec;
        end else begin
          state_d = StIdle;
        end
      end
      StDec: begin
        if (ale_n && !cs_n) begin
          if (hit) begin
            state_d     = StReq;
            loc_req_d   = 1'b1;
            loc_we_d    = ~wr_n;
            loc_wdata_d = ad_in;
            abort_d     = 1'b0;
          end else begin
            state_d = StTurn;
          end
        end else if (!ale_n && cs_n) begin
          // A fresh address phase restarts decoding.
          addr_d[15:0] = {aah8, ad_in};
          state_d      = StAdr1;
        end
      end
      StReq: begin
        if (cs_n) begin
          abort_d = 1'b1;
          ad_oe_d = 1'b0;
        end
        // The local side must always see its handshake complete, even if aborted.
        if (loc_ack) begin
          loc_req_d = 1'b0;
          if (abort_q || cs_n) begin
            state_d = StIdle;
          end else begin
            state_d = StRdy;
            if (!loc_we_q) begin
              ad_out_d = loc_rdata;
              ad_oe_d  = 1'b1;
            end
          end
        end
      end
      StRdy: begin
        if (typ && !cs_n) begin
          addr_d      = addr_q + 32'd1;
          state_d     = StReq;
          loc_req_d   = 1'b1;
          loc_we_d    = ~wr_n;
          loc_wdata_d = ad_in;
          abort_d     = 1'b0;
        end else begin
          state_d = StTurn;
          ad_oe_d = 1'b0;
        end
      end
      StTurn: begin
        ad_oe_d = 1'b0;
        if (cs_n) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_q      <= 32'h0;
      loc_req_q   <= 1'b0;
      loc_we_q    <= 1'b0;
      loc_wdata_q <= 8'h00;
      ad_out_q    <= 8'h00;
      ad_oe_q     <= 1'b0;
      abort_q     <= 1'b0;
      irq_n_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      loc_req_q   <= loc_req_d;
      loc_we_q    <= loc_we_d;
      loc_wdata_q <= loc_wdata_d;
      ad_out_q    <= ad_out_d;
      ad_oe_q     <= ad_oe_d;
      abort_q     <= abort_d;
      irq_n_q     <= ~loc_irq;
    end
  end

  // RDY# decoded from state so reset forces it high without delay.
  assign rdy_n     = (state_q != StRdy);
  assign ad_out    = ad_out_q;
  assign ad_oe     = ad_oe_q;
  assign irq_n     = irq_n_q;
  assign loc_addr  = addr_q;
  assign loc_wdata = loc_wdata_q;
  assign loc_we    = loc_we_q;
  assign loc_req   = loc_req_q;

endmodule

// File: tb/tb_fsb8_target.sv
// Scoreboard bench for fsb8_target: bus master tasks, a local-side responder and
// a monitor popping expected local transactions and RDY# beats.
module tb_fsb8_target;

  logic        clk = 1'b0;
  logic        rst_n, ale_n, cs_n, cmd_n, typ, wr_n;
  logic [7:0]  aah8, ad_in, ad_out, loc_wdata, loc_rdata;
  logic        ad_oe, rdy_n, irq_n, loc_we, loc_req, loc_ack, loc_irq;
  logic [31:0] loc_addr;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [7:0]  wdata;
  } txn_t;

  typedef struct {
    logic       rd;
    logic [7:0] data;
  } beat_t;

  txn_t  exp_q[$];
  beat_t rdy_q[$];
  int    checks = 0;
  int    errors = 0;
  int    rdy_cnt = 0;
  int    ack_delay = 0;
  int    wait_cnt = 0;
  logic  req_prev = 1'b0;

  fsb8_target dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ale_n     (ale_n),
    .cs_n      (cs_n),
    .cmd_n     (cmd_n),
    .typ       (typ),
    .wr_n      (wr_n),
    .aah8      (aah8),
    .ad_in     (ad_in),
    .ad_out    (ad_out),
    .ad_oe     (ad_oe),
    .rdy_n     (rdy_n),
    .irq_n     (irq_n),
    .loc_addr  (loc_addr),
    .loc_wdata (loc_wdata),
    .loc_we    (loc_we),
    .loc_req   (loc_req),
    .loc_ack   (loc_ack),
    .loc_rdata (loc_rdata),
    .loc_irq   (loc_irq)
  );

  always #5 clk = ~clk;

  // Local memory model: read data is a fixed function of the address.
  assign loc_rdata = loc_addr[7:0] ^ 8'hA4;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      loc_ack  = 1'b0;
      wait_cnt = 0;
    end else if (loc_req && !loc_ack) begin
      if (wait_cnt >= ack_delay) begin
        loc_ack  = 1'b1;
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      loc_ack = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      req_prev = 1'b0;
    end else begin
      if (loc_req && !req_prev && exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_req: loc_req=1 at addr %h, required no request", loc_addr);
      end
      if (loc_req && loc_ack) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_txn: addr %h, required none", loc_addr);
        end else begin
          txn_t e;
          e = exp_q.pop_front();
          if (loc_addr !== e.addr || loc_we !== e.we || (e.we && loc_wdata !== e.wdata)) begin
            errors++;
            $display("FAIL local_txn: got addr %h we %b wdata %h, required addr %h we %b wdata %h",
                     loc_addr, loc_we, loc_wdata, e.addr, e.we, e.wdata);
          end
          if (!cs_n) rdy_q.push_back('{rd: !e.we, data: e.addr[7:0] ^ 8'hA4});
        end
      end
      if (!rdy_n) begin
        rdy_cnt++;
        checks++;
        if (rdy_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rdy: rdy_n=0, required 1");
        end else begin
          beat_t b;
          b = rdy_q.pop_front();
          if (ad_oe !== b.rd || (b.rd && ad_out !== b.data)) begin
            errors++;
            $display("FAIL rdy_beat: got ad_oe %b ad_out %h, required ad_oe %b ad_out %h",
                     ad_oe, ad_out, b.rd, b.data);
          end
        end
      end
      req_prev = loc_req;
    end
  end

  task automatic push_exp(input logic [31:0] a, input logic we, input logic [7:0] d);
    exp_q.push_back('{addr: a, we: we, wdata: d});
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic cmd, input logic t, input logic w,
                            input logic [7:0] d);
    @(posedge clk); #1;
    ale_n = 1'b0; cs_n = 1'b1; {aah8, ad_in} = a[15:0];
    @(posedge clk); #1;
    {aah8, ad_in} = a[31:16];
    @(posedge clk); #1;
    ale_n = 1'b1; cs_n = 1'b0; cmd_n = cmd; typ = t; wr_n = w; ad_in = d;
  endtask

  // Waits for n RDY# beats, then ends the cycle by raising cs_n.
  task automatic wait_rdy(input int n);
    int target;
    int cyc;
    target = rdy_cnt + n;
    cyc = 0;
    while (rdy_cnt < target && cyc < 100) begin
      @(negedge clk); #1;
      cyc++;
    end
    checks++;
    if (rdy_cnt < target) begin
      errors++;
      $display("FAIL rdy_timeout: got %0d beats, required %0d", rdy_cnt - target + n, n);
    end
    cs_n = 1'b1;
  endtask

  task automatic bus_idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; ale_n = 1'b1; cs_n = 1'b1; cmd_n = 1'b1; typ = 1'b0; wr_n = 1'b1;
    aah8 = 8'h00; ad_in = 8'h00; loc_irq = 1'b1; loc_ack = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (rdy_n !== 1'b1 || irq_n !== 1'b1) begin
      errors++;
      $display("FAIL reset_rdy_irq: got rdy_n %b irq_n %b, required 1 1", rdy_n, irq_n);
    end
    checks++;
    if (ad_oe !== 1'b0 || ad_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_ad: got ad_oe %b ad_out %h, required 0 00", ad_oe, ad_out);
    end
    checks++;
    if (loc_req !== 1'b0 || loc_we !== 1'b0 || loc_addr !== 32'h0 || loc_wdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_local: got req %b we %b addr %h wdata %h, required 0 0 0 0",
               loc_req, loc_we, loc_addr, loc_wdata);
    end
    loc_irq = 1'b0;
    rst_n = 1'b1;
    bus_idle(2);
  endtask

  task automatic test_single_write;
    int c0;
    ack_delay = 2;
    c0 = rdy_cnt;
    push_exp(32'hC000_0010, 1'b1, 8'h5A);
    addr_phase(32'hC000_0010, 1'b1, 1'b0, 1'b0, 8'h5A);
    wait_rdy(1);
    bus_idle(3);
    checks++;
    if (rdy_cnt - c0 !== 1 || ad_oe !== 1'b0) begin
      errors++;
      $display("FAIL write_pulses: got %0d pulses ad_oe %b, required 1 pulse ad_oe 0",
               rdy_cnt - c0, ad_oe);
    end
  endtask

  task automatic test_single_read;
    ack_delay = 0;
    push_exp(32'hC000_0003, 1'b0, 8'h00);
    addr_phase(32'hC000_0003, 1'b1, 1'b0, 1'b1, 8'h00);
    wait_rdy(1);
    @(negedge clk);
    checks++;
    if (ad_oe !== 1'b0) begin
      errors++;
      $display("FAIL read_oe_release: got ad_oe %b, required 0", ad_oe);
    end
    bus_idle(2);
  endtask

  task automatic test_block_read;
    int c0;
    logic [31:0] a;
    ack_delay = 1;
    c0 = rdy_cnt;
    a = 32'hC000_FFFE;
    for (int i = 0; i < 4; i++) begin
      push_exp(a, 1'b0, 8'h00);
      a = a + 32'd1;
    end
    addr_phase(32'hC000_FFFE, 1'b1, 1'b1, 1'b1, 8'h00);
    wait_rdy(4);
    bus_idle(3);
    checks++;
    if (rdy_cnt - c0 !== 4 || exp_q.size() !== 0 || ad_oe !== 1'b0) begin
      errors++;
      $display("FAIL block_read: got %0d pulses %0d pending ad_oe %b, required 4 0 0",
               rdy_cnt - c0, exp_q.size(), ad_oe);
    end
  endtask

  task automatic test_miss;
    logic [31:0] addrs[2];
    logic        cmds[2];
    logic        bad;
    addrs[0] = 32'h8000_0000; cmds[0] = 1'b1;
    addrs[1] = 32'hC000_0000; cmds[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      addr_phase(addrs[k], cmds[k], 1'b0, 1'b1, 8'h00);
      bad = 1'b0;
      repeat (5) begin
        @(negedge clk);
        if (loc_req !== 1'b0 || rdy_n !== 1'b1 || ad_oe !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL miss_%0d: got activity (req %b rdy_n %b oe %b), required idle outputs",
                 k, loc_req, rdy_n, ad_oe);
      end
      cs_n = 1'b1;
      bus_idle(2);
    end
  endtask

  task automatic test_back_to_back;
    ack_delay = 0;
    push_exp(32'hC000_1234, 1'b1, 8'h3C);
    addr_phase(32'hC000_1234, 1'b1, 1'b0, 1'b0, 8'h3C);
    wait_rdy(1);
    bus_idle(2);
    push_exp(32'hC000_00FF, 1'b0, 8'h00);
    addr_phase(32'hC000_00FF, 1'b1, 1'b0, 1'b1, 8'h00);
    wait_rdy(1);
    bus_idle(2);
  endtask

  task automatic test_abort;
    int c0;
    int hi;
    ack_delay = 5;
    c0 = rdy_cnt;
    hi = 0;
    push_exp(32'hC000_0020, 1'b0, 8'h00);
    addr_phase(32'hC000_0020, 1'b1, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (loc_req) hi++;
      if (i == 2) cs_n = 1'b1;
    end
    checks++;
    if (hi !== ack_delay + 1) begin
      errors++;
      $display("FAIL abort_req_hold: got %0d cycles, required %0d", hi, ack_delay + 1);
    end
    checks++;
    if (rdy_cnt !== c0 || ad_oe !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_rdy: got %0d pulses ad_oe %b, required 0 pulses ad_oe 0",
               rdy_cnt - c0, ad_oe);
    end
    bus_idle(2);
  endtask

  task automatic test_reset_in_rdy;
    int cyc;
    ack_delay = 0;
    cyc = 0;
    push_exp(32'hC000_0004, 1'b0, 8'h00);
    addr_phase(32'hC000_0004, 1'b1, 1'b0, 1'b1, 8'h00);
    do begin
      @(negedge clk);
      cyc++;
    end while (rdy_n !== 1'b0 && cyc < 50);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rdy_n !== 1'b1 || ad_oe !== 1'b0 || loc_req !== 1'b0 || cyc >= 50) begin
      errors++;
      $display("FAIL reset_in_rdy: got rdy_n %b ad_oe %b loc_req %b, required 1 0 0",
               rdy_n, ad_oe, loc_req);
    end
    cs_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    bus_idle(2);
  endtask

  task automatic test_irq;
    logic [9:0] pat;
    logic       prev;
    int         low;
    pat = 10'b0001110000;
    prev = loc_irq;
    low = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (irq_n !== ~prev) begin
        errors++;
        $display("FAIL irq_%0d: got irq_n %b, required %b", i, irq_n, ~prev);
      end
      if (!irq_n) low++;
      loc_irq = pat[i];
      prev = pat[i];
    end
    @(posedge clk); #1;
    checks++;
    if (low !== 3 || irq_n !== 1'b1) begin
      errors++;
      $display("FAIL irq_width: got %0d low cycles irq_n %b, required 3 and 1", low, irq_n);
    end
  endtask

  initial begin
    test_reset;
    test_single_write;
    test_single_read;
    test_block_read;
    test_miss;
    test_back_to_back;
    test_abort;
    test_reset_in_rdy;
    test_irq;
    checks++;
    if (exp_q.size() !== 0 || rdy_q.size() !== 0) begin
      errors++;
      $display("FAIL leftover: got %0d txns %0d beats pending, required 0 0",
               exp_q.size(), rdy_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
